// File: rtl/fpaddsub_share_arbiter.sv
// Round-robin front end sharing one fixed-latency FP add/sub unit.
// Issues are tag-tracked through the pipe and returned through a credited FIFO.
module fpaddsub_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DWIDTH     = 16,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TAGW       = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DWIDTH-1:0] req_a,
  input  logic [NUM_REQ*DWIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_op,
  output logic                      add_issue,
  output logic [DWIDTH-1:0]         add_a,
  output logic [DWIDTH-1:0]         add_b,
  output logic                      add_op,
  input  logic [DWIDTH-1:0]         add_result,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [TAGW-1:0]           resp_tag,
  output logic [DWIDTH-1:0]         resp_data,
  output logic                      busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = TAGW + DWIDTH;

  logic [TAGW-1:0]   rr_q;
  logic [CW-1:0]     credits_q;
  logic [CW-1:0]     credits_d;
  logic              issue_q;
  logic [DWIDTH-1:0] a_q;
  logic [DWIDTH-1:0] b_q;
  logic              op_q;
  logic [TAGW-1:0]   itag_q;
  logic [PIPE_LAT-1:0] vld_q;
  logic [TAGW-1:0]   stag_q [PIPE_LAT];
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;
  logic [FW-1:0]     mem_q [FIFO_DEPTH];

  logic              gnt_found;
  logic [TAGW-1:0]   gnt_idx;
  logic              hs;
  logic              push;
  logic              pop;
  logic [FW-1:0]     head;

  function automatic logic [TAGW-1:0] wrap_idx(
    input logic [TAGW-1:0] base,
    input int              off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return TAGW'(s);
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[wrap_idx(rr_q, i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(rr_q, i);
      end
    end
  end

  // A grant needs a credit so every issued op already owns a FIFO slot
  assign hs        = gnt_found && (credits_q != '0) && resetn;
  assign req_ready = hs ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign push       = vld_q[PIPE_LAT-1];
  assign resp_valid = (wptr_q != rptr_q);
  assign pop        = resp_valid && resp_ready;
  assign head       = mem_q[rptr_q[AW-1:0]];
  assign resp_tag   = resp_valid ? head[FW-1:DWIDTH] : '0;
  assign resp_data  = resp_valid ? head[DWIDTH-1:0] : '0;

  assign add_issue = issue_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_op    = op_q;
  assign busy      = (|vld_q) || resp_valid || issue_q;

  always_comb begin
    credits_d = credits_q;
    if (hs && !pop)      credits_d = credits_q - CW'(1);
    else if (!hs && pop) credits_d = credits_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_q      <= '0;
      credits_q <= CW'(FIFO_DEPTH);
      issue_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      itag_q    <= '0;
      vld_q     <= '0;
      for (int k = 0; k < PIPE_LAT; k++) stag_q[k] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      issue_q   <= hs;
      credits_q <= credits_d;
      if (hs) begin
        a_q    <= req_a[gnt_idx*DWIDTH +: DWIDTH];
        b_q    <= req_b[gnt_idx*DWIDTH +: DWIDTH];
        op_q   <= req_op[gnt_idx];
        itag_q <= gnt_idx;
        rr_q   <= wrap_idx(gnt_idx, 1);
      end
      vld_q[0]  <= issue_q;
      stag_q[0] <= itag_q;
      for (int k = 1; k < PIPE_LAT; k++) begin
        vld_q[k]  <= vld_q[k-1];
        stag_q[k] <= stag_q[k-1];
      end
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {stag_q[PIPE_LAT-1], add_result};
  end

endmodule
